// File: rtl/intercom_pkg.sv
// Shared arbitration types and round-robin sizing helpers for the Intercom
// bus fabric and its requester-side arbiter.
package intercom_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   localparam int unsigned RR_MIN_MASTERS = 2;
   localparam int unsigned RR_MAX_MASTERS = 8;

   // Width of a round-robin index able to address n requesters (at least 1 bit).
   function automatic int unsigned rr_idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: starting just after the previous
// winner, returns the first active request as a one-hot grant plus its index.
module rr_picker
   import intercom_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = rr_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand;

   // Scan requests in rotating order last+1 .. last+N (mod N); first hit wins.
   always_comb begin
      // NOTE: every output of this block gets a value before any branch so no latch is inferred.
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int off = 1; off <= int'(NUM_REQ); off++) begin
         cand = IDX_W'((int'(last_i) + off) % int'(NUM_REQ));
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/intercom_arbiter.sv
// Round-robin Wishbone B3 arbiter: one owner at a time, locked for its whole
// cyc burst, with responses routed only to the owner and a stall watchdog.
module intercom_arbiter
   import intercom_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 3,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_MASTERS-1:0]               m_cyc_i,
   input  logic [NUM_MASTERS-1:0]               m_stb_i,
   input  logic [NUM_MASTERS-1:0]               m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
   input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  m_sel_i,
   output logic [DATA_WIDTH-1:0]                m_dat_o,
   output logic [NUM_MASTERS-1:0]               m_ack_o,
   output logic [NUM_MASTERS-1:0]               m_err_o,
   output logic                                 s_cyc_o,
   output logic                                 s_stb_o,
   output logic                                 s_we_o,
   output logic [ADDR_WIDTH-1:0]                s_adr_o,
   output logic [DATA_WIDTH-1:0]                s_dat_o,
   output logic [SELECT_WIDTH-1:0]              s_sel_o,
   input  logic [DATA_WIDTH-1:0]                s_dat_i,
   input  logic                                 s_ack_i,
   input  logic                                 s_err_i,
   output logic [NUM_MASTERS-1:0]               grant_o,
   output logic                                 timeout_o
);

   localparam int unsigned LW    = rr_idx_w(NUM_MASTERS);
   localparam int unsigned CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
   // The watchdog fires during the stall cycle in which the count would reach the limit.
   localparam logic [CW-1:0] WD_LIMIT = WD_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [LW-1:0]          last_q, last_d;
   logic [CW-1:0]          wd_cnt_q, wd_cnt_d;
   logic                   pend_q, pend_d;        // owner has an unterminated strobe outstanding
   logic                   discard_q, discard_d;  // swallow a response that belongs to an aborted access

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [LW-1:0]          pick_idx;
   logic                   pick_valid;
   logic                   own_cyc, own_stb;
   logic                   owned, release_now, ack_eff, err_eff, stalled, wd_fire;

   rr_picker #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (LW)
   ) u_picker (
      .req_i   (m_cyc_i),
      .last_i  (last_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // One-hot AND-OR mux of the owner's request signals onto the slave side.
   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
         if (grant_q[k]) begin
            own_cyc = m_cyc_i[k];
            own_stb = m_stb_i[k];
            s_we_o  = m_we_i[k];
            s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = m_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
         end
      end
   end

   assign owned       = (state_q == OWNED);
   assign release_now = owned && !own_cyc;
   assign ack_eff     = s_ack_i && !discard_q;
   assign err_eff     = s_err_i && !discard_q;
   assign s_cyc_o     = owned && own_cyc;
   assign stalled     = s_cyc_o && own_stb && !ack_eff && !err_eff;
   assign wd_fire     = WD_EN && stalled && (wd_cnt_q == WD_LIMIT);
   assign s_stb_o     = s_cyc_o && own_stb && !wd_fire;
   assign m_ack_o     = grant_q & m_cyc_i & {NUM_MASTERS{ack_eff}};
   assign m_err_o     = grant_q & m_cyc_i & {NUM_MASTERS{err_eff || wd_fire}};
   assign m_dat_o     = s_dat_i;
   assign timeout_o   = wd_fire;
   assign grant_o     = grant_q;

   // Next-state: grant on request in IDLE, hand off or go idle when the owner drops cyc.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      wd_cnt_d  = (WD_EN && stalled && !wd_fire) ? wd_cnt_q + CW'(1) : '0;
      pend_d    = stalled && !wd_fire;
      discard_d = release_now && pend_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_gnt;
               last_d  = pick_idx;
               state_d = OWNED;
            end
         end
         OWNED: begin
            if (release_now) begin
               if (pick_valid) begin
                  grant_d = pick_gnt;
                  last_d  = pick_idx;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter state, registered grant and watchdog, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= LAST_RST;
         wd_cnt_q  <= '0;
         pend_q    <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         wd_cnt_q  <= wd_cnt_d;
         pend_q    <= pend_d;
         discard_q <= discard_d;
      end
   end

endmodule

// File: tb/tb_intercom_arbiter.sv
// Scoreboard bench for intercom_arbiter: a behavioural model predicts each
// observable bus event; a separate monitor compares DUT events in order.
module tb_intercom_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
   logic [N*AW-1:0] m_adr = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [N*SW-1:0] m_sel = '0;
   logic [DW-1:0]   m_dat_o;
   logic [N-1:0]    m_ack_o, m_err_o, grant_o;
   logic            s_cyc_o, s_stb_o, s_we_o, timeout_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [SW-1:0]   s_sel_o;
   logic [DW-1:0]   s_dat = '0;
   logic            s_ack = 1'b0, s_err = 1'b0;

   intercom_arbiter #(
      .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_no = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc_no <= cyc_no + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   typedef struct {
      int            cyc;
      logic [N-1:0]  grant, ack, err;
      logic          tmo, scyc, sstb, swe;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat, mdat;
      logic [SW-1:0] sel;
   } event_t;

   event_t exp_q[$];

   // ---------------- behavioural reference model ----------------
   int           owner = -1;   // -1: nobody owns the bus
   int           last  = N-1;
   int           stall = 0;
   bit           late  = 1'b0; // a response this cycle belongs to an abandoned access
   bit           outst = 1'b0; // the owner's strobe was left unanswered last cycle
   logic [N-1:0] mdl_prev_g = '0;

   function automatic int rr_next(input int from, input logic [N-1:0] req);
      for (int i = 1; i <= N; i++)
         if (req[(from + i) % N]) return (from + i) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         event_t e;
         bit ocyc, ostb, ack_ok, err_ok, stl, fire;
         int nx;
         e.grant = (owner >= 0) ? N'(1 << owner) : '0;
         ocyc    = (owner >= 0) && m_cyc[owner];
         ostb    = ocyc && m_stb[owner];
         ack_ok  = s_ack && !late;
         err_ok  = s_err && !late;
         stl     = ostb && !ack_ok && !err_ok;
         fire    = stl && (stall == TO - 1);
         e.cyc   = cyc_no;
         e.scyc  = ocyc;
         e.sstb  = ostb && !fire;
         e.ack   = (ocyc && ack_ok) ? e.grant : '0;
         e.err   = (ocyc && (err_ok || fire)) ? e.grant : '0;
         e.tmo   = fire;
         e.mdat  = s_dat;
         e.swe   = (owner >= 0) ? m_we[owner] : 1'b0;
         e.adr   = (owner >= 0) ? m_adr[owner*AW +: AW] : '0;
         e.dat   = (owner >= 0) ? m_dat[owner*DW +: DW] : '0;
         e.sel   = (owner >= 0) ? m_sel[owner*SW +: SW] : '0;
         if (e.grant != mdl_prev_g || e.ack != 0 || e.err != 0 || e.tmo || e.scyc)
            exp_q.push_back(e);
         mdl_prev_g = e.grant;
         if (rst) begin
            owner = -1; last = N-1; stall = 0; late = 1'b0; outst = 1'b0;
         end else begin
            late  = (owner >= 0) && !ocyc && outst;
            outst = stl && !fire;
            stall = (stl && !fire) ? stall + 1 : 0;
            if (owner < 0) begin
               nx = rr_next(last, m_cyc);
               if (nx >= 0) begin owner = nx; last = nx; end
            end else if (!m_cyc[owner]) begin
               nx = rr_next(last, m_cyc);
               owner = nx;
               if (nx >= 0) last = nx;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   logic [N-1:0] mon_prev_g = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         #1;
         if (grant_o !== mon_prev_g || m_ack_o != 0 || m_err_o != 0 || timeout_o || s_cyc_o) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_event: grant=%b ack=%b err=%b tmo=%b cyc=%b with no expected event (cycle %0d)",
                        grant_o, m_ack_o, m_err_o, timeout_o, s_cyc_o, cyc_no);
            end else begin
               event_t e;
               e = exp_q.pop_front();
               check("event_cycle", 64'(cyc_no), 64'(e.cyc));
               check("grant_o", 64'(grant_o), 64'(e.grant));
               check("m_ack_o", 64'(m_ack_o), 64'(e.ack));
               check("m_err_o", 64'(m_err_o), 64'(e.err));
               check("timeout_o", 64'(timeout_o), 64'(e.tmo));
               check("s_cyc_o", 64'(s_cyc_o), 64'(e.scyc));
               check("s_stb_o", 64'(s_stb_o), 64'(e.sstb));
               check("m_dat_o", 64'(m_dat_o), 64'(e.mdat));
               if (e.scyc) begin
                  check("s_we_o", 64'(s_we_o), 64'(e.swe));
                  check("s_adr_o", 64'(s_adr_o), 64'(e.adr));
                  check("s_dat_o", 64'(s_dat_o), 64'(e.dat));
                  check("s_sel_o", 64'(s_sel_o), 64'(e.sel));
               end
            end
         end
         mon_prev_g = grant_o;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_cyc[k] = 1'b1;
      m_stb[k] = 1'b1;
      m_we[k]  = we;
      m_adr[k*AW +: AW] = a;
      m_dat[k*DW +: DW] = d;
      m_sel[k*SW +: SW] = '1;
   endtask

   task automatic clr_m(input int k);
      m_cyc[k] = 1'b0;
      m_stb[k] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int beats_left[N];
   bit active[N];
   bit cool[N];

   task automatic new_beat(input int k);
      m_stb[k] = 1'b1;
      m_we[k]  = 1'($urandom);
      m_adr[k*AW +: AW] = $urandom;
      m_dat[k*DW +: DW] = $urandom;
      m_sel[k*SW +: SW] = SW'($urandom);
   endtask

   // Randomised requesters and slave; a requester drops cyc after its beats
   // are terminated and stays low for at least one cycle.
   task automatic run(input int ncyc, input int start_pct, input int bmin, input int bmax,
                      input int ack_pct, input int err_pct, input int abort_pct, input logic [N-1:0] en);
      logic [N-1:0] term;
      term = '0;
      for (int c = 0; c < ncyc; c++) begin
         for (int k = 0; k < N; k++) begin
            if (term[k] && active[k]) begin
               beats_left[k]--;
               if (beats_left[k] == 0) begin
                  active[k] = 1'b0; cool[k] = 1'b1; clr_m(k);
               end else new_beat(k);
            end else if (active[k] && int'($urandom % 100) < abort_pct) begin
               active[k] = 1'b0; cool[k] = 1'b1; clr_m(k);
            end else if (!active[k] && !cool[k] && en[k] && int'($urandom % 100) < start_pct) begin
               active[k] = 1'b1;
               beats_left[k] = bmin + int'($urandom % (bmax - bmin + 1));
               m_cyc[k] = 1'b1;
               new_beat(k);
            end else cool[k] = 1'b0;
         end
         s_ack = int'($urandom % 100) < ack_pct;
         s_err = !s_ack && int'($urandom % 100) < err_pct;
         s_dat = $urandom;
         @(negedge clk);
         #2;
         term = m_ack_o | m_err_o;
         tick();
      end
      for (int k = 0; k < N; k++) begin
         active[k] = 1'b0; cool[k] = 1'b0; clr_m(k);
      end
      s_ack = 1'b0;
      s_err = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      mon_en = 1'b1;
      check("reset_grant", 64'(grant_o), 64'd0);
      check("reset_s_cyc", 64'(s_cyc_o), 64'd0);
      check("reset_s_stb", 64'(s_stb_o), 64'd0);
      check("reset_s_adr", 64'(s_adr_o), 64'd0);
      check("reset_ack_err_tmo", 64'({m_ack_o, m_err_o, timeout_o}), 64'd0);

      // Contention straight after reset: order 0,1,2 then 0 again.
      run(14, 100, 1, 1, 100, 0, 0, 3'b111);

      // Single requester: master 1 writes 0xDEADBEEF to 0x10, slave acks later.
      set_m(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      tick(); tick(); tick();
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      clr_m(1); tick(); tick();

      // Burst lock: master 0 runs 4 beats while master 2 waits.
      do_reset();
      run(16, 100, 4, 4, 60, 0, 0, 3'b101);

      // Silent slave: watchdog fires on stall cycle 8.
      set_m(0, 1'b0, 32'h100, 32'h0);
      tick();
      repeat (10) tick();
      clr_m(0); tick(); tick();

      // Ack on stall cycle 8: the slave response wins over the watchdog.
      set_m(0, 1'b0, 32'h104, 32'h0);
      tick();
      repeat (7) tick();
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      clr_m(0); tick(); tick();

      // Abort and late ack: owner 0 drops cyc, slave acks one cycle later.
      do_reset();
      set_m(0, 1'b1, 32'h200, 32'h1111_2222);
      set_m(1, 1'b0, 32'h300, 32'h3333_4444);
      tick(); tick(); tick();
      clr_m(0); tick();
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      tick();
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      clr_m(1); tick(); tick();

      // Reset mid-burst, then master 0 must win first.
      set_m(1, 1'b1, 32'h400, 32'h5);
      set_m(2, 1'b1, 32'h500, 32'h6);
      tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      set_m(0, 1'b0, 32'h600, 32'h7);
      tick(); tick();
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      clr_m(0); clr_m(1); clr_m(2);
      tick(); tick();

      // Randomised traffic: mixed, stall-heavy (timeouts), and abort/err-heavy.
      run(300, 30, 1, 4, 50, 5, 2, 3'b111);
      run(200, 30, 1, 3, 5, 0, 0, 3'b111);
      run(150, 40, 1, 4, 70, 10, 5, 3'b111);

      mon_en = 1'b0;
      #2;
      check("leftover_expected_events", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
